ddr3_init_refresh_seq: RTL and testbench

- Parametrised DDR3 power-up sequencer and periodic refresh engine, one clock domain.
- Drives reset_n/CKE/ODT, performs the JEDEC MRS2-MRS3-MRS1-MRS0-ZQCL init with mode-register values supplied on input ports, then schedules auto-refresh.
- Refresh is arbitrated against the user command path through a request/grant handshake, with a postponed-refresh credit counter of up to 8.
- Sits between the PHY pin drivers and the read/write command scheduler.

---
 rtl/ddr3_init_refresh_seq.sv | 191 +++++++++++++++++++
 tb/tb_ddr3_init_refresh_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ddr3_init_refresh_seq.sv
// ddr3_init_refresh_seq: DDR3 power-up (reset/CKE, MRS2-3-1-0, ZQCL) then credit-based auto-refresh arbitration.
// Defining SELF_REFRESH_EN adds sr_req/sr_active and self-refresh entry/exit states.
module ddr3_init_refresh_seq #(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int T_RESET_US   = 200,
  parameter int T_CKE_US     = 500,
  parameter int T_XPR        = 120,
  parameter int T_MRD        = 4,
  parameter int T_MOD        = 12,
  parameter int T_ZQINIT     = 512,
  parameter int T_RP         = 6,
  parameter int T_RFC        = 88,
  parameter int T_REFI       = 780,
  parameter int ADDR_W       = 14,
  parameter int BA_W         = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mr0,
  input  logic [ADDR_W-1:0] mr1,
  input  logic [ADDR_W-1:0] mr2,
  input  logic [ADDR_W-1:0] mr3,
  output logic              init_done,
  output logic              ref_req,
  input  logic              ref_gnt,
  output logic              ref_busy,
  output logic [3:0]        cmd_csrcw,
  output logic [ADDR_W-1:0] ddr3_addr_out,
  output logic [BA_W-1:0]   ddr3_ba_out,
  output logic              ddr3_cke_out,
  output logic              ddr3_odt_out,
  output logic              ddr3_reset_out,
  output logic              ddr3_ck_oe
`ifdef SELF_REFRESH_EN
  ,
  input  logic              sr_req,
  output logic              sr_active
`endif
);
  typedef enum logic [3:0] {
    RST_HOLD, CKE_WAIT, XPR, MRS2, MRS3, MRS1, MRS0, ZQCL, IDLE, PREA, REF
`ifdef SELF_REFRESH_EN
    , SR_PREA, SRE, SR_ACT, SR_EXIT
`endif
  } state_t;
  localparam logic [3:0] NOP = 4'b0111, MRS = 4'b0000, ZQC = 4'b0110, PRE = 4'b0010, RFC = 4'b0001;
  localparam int DW = CLK_FREQ_MHZ > 1 ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_FREQ_MHZ > 1 ? CLK_FREQ_MHZ - 1 : 0);
  // wait limits are N-1 so the next command lands exactly N cycles later; N=0 behaves as 1
  localparam logic [31:0] L_RST  = T_RESET_US > 1 ? 32'(T_RESET_US - 1) : 32'd0;
  localparam logic [31:0] L_CKE  = T_CKE_US > 1 ? 32'(T_CKE_US - 1) : 32'd0;
  localparam logic [31:0] L_XPR  = T_XPR > 1 ? 32'(T_XPR - 1) : 32'd0;
  localparam logic [31:0] L_MRD  = T_MRD > 1 ? 32'(T_MRD - 1) : 32'd0;
  localparam logic [31:0] L_MOD  = T_MOD > 1 ? 32'(T_MOD - 1) : 32'd0;
  localparam logic [31:0] L_ZQ   = T_ZQINIT > 1 ? 32'(T_ZQINIT - 1) : 32'd0;
  localparam logic [31:0] L_RP   = T_RP > 1 ? 32'(T_RP - 1) : 32'd0;
  localparam logic [31:0] L_RFC  = T_RFC > 1 ? 32'(T_RFC - 1) : 32'd0;
  localparam logic [31:0] L_REFI = T_REFI > 1 ? 32'(T_REFI - 1) : 32'd0;
  localparam logic [ADDR_W-1:0] A10 = ADDR_W'(1) << 10;
  state_t state, nxt;
  logic [31:0] cnt, refi;
  logic [DW-1:0] div;
  logic [3:0] credits;
  logic tick, step, run, refi_wrap, add, sub, clr, sr_on, overflow;
  assign tick = div == DIV_MAX;
  assign ref_req = state == IDLE && credits != 4'd0;
  assign ddr3_odt_out = 1'b0;
  assign run = init_done && !sr_on;
  assign refi_wrap = run && refi == L_REFI;
  assign add = refi_wrap;
  assign sub = state == REF && nxt == IDLE;
`ifdef SELF_REFRESH_EN
  localparam logic [31:0] L_SRX = 32'(T_RFC + 9);
  assign sr_active = state == SR_ACT;
  assign sr_on = sr_active;
  assign clr = state == SR_EXIT && nxt == IDLE;
`else
  assign sr_on = 1'b0;
  assign clr = 1'b0;
`endif
  always_comb begin
    nxt = state;
    step = 1'b1;
    cmd_csrcw = NOP;
    ddr3_addr_out = '0;
    ddr3_ba_out = '0;
    ddr3_cke_out = 1'b1;
    ddr3_reset_out = 1'b1;
    ddr3_ck_oe = 1'b1;
    ref_busy = 1'b0;
    case (state)
      RST_HOLD: begin
        {ddr3_cke_out, ddr3_reset_out, ddr3_ck_oe} = 3'b000;
        step = tick;
        if (tick && cnt == L_RST) nxt = CKE_WAIT;
      end
      CKE_WAIT: begin
        ddr3_cke_out = 1'b0;
        step = tick;
        if (tick && cnt == L_CKE) nxt = XPR;
      end
      XPR: if (cnt == L_XPR) nxt = MRS2;
      MRS2: begin
        {cmd_csrcw, ddr3_ba_out, ddr3_addr_out} = {MRS, BA_W'(2), mr2};
        if (cnt == L_MRD) nxt = MRS3;
      end
      MRS3: begin
        {cmd_csrcw, ddr3_ba_out, ddr3_addr_out} = {MRS, BA_W'(3), mr3};
        if (cnt == L_MRD) nxt = MRS1;
      end
      MRS1: begin
        {cmd_csrcw, ddr3_ba_out, ddr3_addr_out} = {MRS, BA_W'(1), mr1};
        if (cnt == L_MRD) nxt = MRS0;
      end
      MRS0: begin
        {cmd_csrcw, ddr3_addr_out} = {MRS, mr0};
        if (cnt == L_MOD) nxt = ZQCL;
      end
      ZQCL: begin
        {cmd_csrcw, ddr3_addr_out} = {ZQC, A10};
        if (cnt == L_ZQ) nxt = IDLE;
      end
      IDLE: begin
        step = 1'b0;
        if (ref_req && ref_gnt) nxt = PREA;
`ifdef SELF_REFRESH_EN
        else if (sr_req) nxt = SR_PREA;
`endif
      end
      PREA: begin
        ref_busy = 1'b1;
        {cmd_csrcw, ddr3_addr_out} = {PRE, A10};
        if (cnt == L_RP) nxt = REF;
      end
      REF: begin
        ref_busy = 1'b1;
        cmd_csrcw = RFC;
        if (cnt == L_RFC) nxt = IDLE;
      end
`ifdef SELF_REFRESH_EN
      SR_PREA: begin
        ref_busy = 1'b1;
        {cmd_csrcw, ddr3_addr_out} = {PRE, A10};
        if (cnt == L_RP) nxt = SRE;
      end
      SRE: begin
        ref_busy = 1'b1;
        cmd_csrcw = RFC;
        ddr3_cke_out = 1'b0;
        nxt = SR_ACT;
      end
      SR_ACT: begin
        ref_busy = 1'b1;
        ddr3_cke_out = 1'b0;
        step = 1'b0;
        if (!sr_req) nxt = SR_EXIT;
      end
      SR_EXIT: begin
        ref_busy = 1'b1;
        if (cnt == L_SRX) nxt = IDLE;
      end
`endif
      default: nxt = RST_HOLD;
    endcase
    // commands occupy only the first cycle of their state; the rest of the wait is NOP
    if (cnt != 32'd0) begin
      cmd_csrcw = NOP;
      ddr3_addr_out = '0;
      ddr3_ba_out = '0;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= RST_HOLD;
      cnt <= '0;
      div <= '0;
      refi <= '0;
      credits <= '0;
      init_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? '0 : step ? cnt + 32'd1 : cnt;
      div <= tick ? '0 : div + DW'(1);
      refi <= !run ? refi : refi_wrap ? '0 : refi + 32'd1;
      credits <= clr ? '0 : add && !sub && credits != 4'd8 ? credits + 4'd1 : sub && !add ? credits - 4'd1 : credits;
      init_done <= init_done | (state == ZQCL && nxt == IDLE);
      overflow <= overflow | (credits == 4'd8);
    end
  credit_overflow: cover property (@(posedge clk) overflow);
endmodule

// File: tb/tb_ddr3_init_refresh_seq.sv
// tb_ddr3_init_refresh_seq: scoreboard bench; stimulus queues expected command/pin events, a negedge monitor checks them.
module tb_ddr3_init_refresh_seq;
  localparam logic [3:0] NOP = 4'b0111, MRS = 4'b0000, ZQC = 4'b0110, PRE = 4'b0010, RFC = 4'b0001;
  localparam logic [6:0] F_RST = 7'b1100000, F_CKE = 7'b1110000, F_INIT = 7'b1110100;
  localparam logic [6:0] F_REQ = 7'b1110101, F_BUSY = 7'b1110110;
  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  cmd;
    logic [2:0]  ba;
    logic [13:0] addr;
    logic [6:0]  flags;
  } ev_t;
  logic clk, rst, ref_gnt, init_done, ref_req, ref_busy;
  logic ddr3_cke_out, ddr3_odt_out, ddr3_reset_out, ddr3_ck_oe;
  logic [3:0] cmd_csrcw;
  logic [13:0] ddr3_addr_out, mr0, mr1, mr2, mr3;
  logic [2:0] ddr3_ba_out;
  logic [6:0] prev;
  int cyc, tests, fails;
  ev_t q[$];
  string nq[$];
  ddr3_init_refresh_seq #(
    .CLK_FREQ_MHZ(2), .T_RESET_US(4), .T_CKE_US(5), .T_XPR(10), .T_MRD(4), .T_MOD(12),
    .T_ZQINIT(20), .T_RP(2), .T_RFC(2), .T_REFI(50), .ADDR_W(14), .BA_W(3)
  ) dut (
    .clk(clk), .rst(rst), .mr0(mr0), .mr1(mr1), .mr2(mr2), .mr3(mr3),
    .init_done(init_done), .ref_req(ref_req), .ref_gnt(ref_gnt), .ref_busy(ref_busy),
    .cmd_csrcw(cmd_csrcw), .ddr3_addr_out(ddr3_addr_out), .ddr3_ba_out(ddr3_ba_out),
    .ddr3_cke_out(ddr3_cke_out), .ddr3_odt_out(ddr3_odt_out),
    .ddr3_reset_out(ddr3_reset_out), .ddr3_ck_oe(ddr3_ck_oe)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;
  function automatic logic [6:0] flg();
    return {ddr3_reset_out, ddr3_ck_oe, ddr3_cke_out, ddr3_odt_out, init_done, ref_busy, ref_req};
  endfunction
  task automatic ex(input string n, input int c, input logic [3:0] cm, input logic [2:0] b,
                    input logic [13:0] a, input logic [6:0] f);
    q.push_back('{32'(c), cm, b, a, f});
    nq.push_back(n);
  endtask
  task automatic push_init(input int n);
    ev_t e[8];
    string s[8];
    e = '{'{32'd8, NOP, 3'd0, 14'h0, F_RST}, '{32'd18, NOP, 3'd0, 14'h0, F_CKE},
          '{32'd28, MRS, 3'd2, mr2, F_CKE}, '{32'd32, MRS, 3'd3, mr3, F_CKE},
          '{32'd36, MRS, 3'd1, mr1, F_CKE}, '{32'd40, MRS, 3'd0, mr0, F_CKE},
          '{32'd52, ZQC, 3'd0, 14'h0400, F_CKE}, '{32'd72, NOP, 3'd0, 14'h0, F_INIT}};
    s = '{"reset_out", "cke", "mrs2", "mrs3", "mrs1", "mrs0", "zqcl", "init_done"};
    for (int i = 0; i < n; i++) begin
      q.push_back(e[i]);
      nq.push_back(s[i]);
    end
  endtask
  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc != n && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != n) begin
      tests++;
      fails++;
      $display("FAIL wait_cyc: reached cycle %0d, required %0d", cyc, n);
    end
  endtask
  task automatic chk_rst();
    tests++;
    if ({cmd_csrcw, ddr3_addr_out, ddr3_ba_out, flg()} !== {NOP, 14'h0, 3'h0, 7'h0}) begin
      fails++;
      $display("FAIL async_reset: cmd=%b addr=%h ba=%0d flags=%b, required cmd=0111 addr=0 ba=0 flags=0",
               cmd_csrcw, ddr3_addr_out, ddr3_ba_out, flg());
    end
  endtask
  always @(negedge clk) begin
    ev_t g, e;
    string n;
    g = '{32'(cyc), cmd_csrcw, ddr3_ba_out, ddr3_addr_out, flg()};
    if (cmd_csrcw !== NOP || g.flags !== prev) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected: cyc=%0d cmd=%b ba=%0d addr=%h flags=%b, required no event",
                 g.cyc, g.cmd, g.ba, g.addr, g.flags);
      end else begin
        e = q.pop_front();
        n = nq.pop_front();
        if (g !== e) begin
          fails++;
          $display("FAIL %s: cyc=%0d cmd=%b ba=%0d addr=%h flags=%b, required cyc=%0d cmd=%b ba=%0d addr=%h flags=%b",
                   n, g.cyc, g.cmd, g.ba, g.addr, g.flags, e.cyc, e.cmd, e.ba, e.addr, e.flags);
        end
      end
    end
    prev = g.flags;
  end
  initial begin
    tests = 0;
    fails = 0;
    prev = '0;
    rst = 1'b1;
    ref_gnt = 1'b1;
    {mr0, mr1, mr2, mr3} = {14'h0520, 14'h0046, 14'h0218, 14'h0004};
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    push_init(8);
    #1 rst = 1'b1;
    wait_cyc(72);
    // first credit lands 50 cycles after init_done; grant already high
    ex("req1", 122, NOP, 3'd0, 14'h0, F_REQ);
    ex("prea1", 123, PRE, 3'd0, 14'h0400, F_BUSY);
    ex("ref1", 125, RFC, 3'd0, 14'h0, F_BUSY);
    ex("idle1", 127, NOP, 3'd0, 14'h0, F_INIT);
    wait_cyc(130);
    ref_gnt = 1'b0;
    ex("req_hold", 172, NOP, 3'd0, 14'h0, F_REQ);
    wait_cyc(622);
    ref_gnt = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ex("prea_burst", 623 + 5 * k, PRE, 3'd0, 14'h0400, F_BUSY);
      ex("ref_burst", 625 + 5 * k, RFC, 3'd0, 14'h0, F_BUSY);
      ex("idle_burst", 627 + 5 * k, NOP, 3'd0, 14'h0, k == 7 ? F_INIT : F_REQ);
    end
    wait_cyc(665);
    ex("reset_idle", 0, NOP, 3'd0, 14'h0, 7'h0);
    #1 rst = 1'b0;
    #1 chk_rst();
    repeat (3) @(negedge clk);
    {mr0, mr1, mr2, mr3} = {14'h1d71, 14'h0a05, 14'h0010, 14'h2003};
    push_init(5);
    #1 rst = 1'b1;
    wait_cyc(38);
    ex("reset_mrs1", 0, NOP, 3'd0, 14'h0, 7'h0);
    #1 rst = 1'b0;
    #1 chk_rst();
    repeat (2) @(negedge clk);
    push_init(8);
    #1 rst = 1'b1;
    wait_cyc(80);
    while (q.size() != 0) begin
      ev_t e;
      string n;
      e = q.pop_front();
      n = nq.pop_front();
      tests++;
      fails++;
      $display("FAIL %s: no event seen, required cyc=%0d cmd=%b flags=%b", n, e.cyc, e.cmd, e.flags);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
